scma_host_bridge: RTL and testbench

- Command sequencer that sits directly upstream of the 16-chip SCMA array and owns its `a_in`/`data_in` bus.
- Converts a valid/ready host command stream (single-chip write, broadcast write, single-chip read) into chip-select/address/data sequencing.
- Honours array back-pressure (`full`) and data availability (`empty`).
- Returns exactly one in-order response per command on a valid/ready response channel.

---
 rtl/scma_pkg.sv | 30 +++
 rtl/scma_host_bridge_if.sv | 27 ++
 rtl/scma_chip_sel_dec.sv | 19 +
 rtl/scma_host_bridge.sv | 140 ++++++++++++++
 tb/tb_scma_host_bridge.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/scma_pkg.sv
// Shared widths, FSM states and op codes for the SCMA host bridge.
package scma_pkg;

    localparam int unsigned ADDR_IN_WIDTH  = 11;
    localparam int unsigned CHIP_EN_NUM    = 16;
    localparam int unsigned CHIP_ID_WIDTH  = 4;
    localparam int unsigned DATA_IN_WIDTH  = 36;
    localparam int unsigned DATA_OUT_WIDTH = 32;
    localparam int unsigned A_WIDTH        = ADDR_IN_WIDTH + CHIP_EN_NUM;

    localparam logic OP_WR = 1'b0;
    localparam logic OP_RD = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RD_LAT,
        RESP
    } state_e;

    typedef struct packed {
        logic                     op;
        logic                     bcast;
        logic [CHIP_ID_WIDTH-1:0] chip;
        logic [ADDR_IN_WIDTH-1:0] addr;
        logic [DATA_IN_WIDTH-1:0] data;
    } cmd_t;

endpackage

// File: rtl/scma_host_bridge_if.sv
// Host-side command/response channels of the SCMA host bridge.
interface scma_host_bridge_if;
    import scma_pkg::*;

    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_op;
    logic                      cmd_bcast;
    logic [CHIP_ID_WIDTH-1:0]  cmd_chip;
    logic [ADDR_IN_WIDTH-1:0]  cmd_addr;
    logic [DATA_IN_WIDTH-1:0]  cmd_data;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_OUT_WIDTH-1:0] rsp_data;
    logic                      rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_bcast, cmd_chip, cmd_addr, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_bcast, cmd_chip, cmd_addr, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/scma_chip_sel_dec.sv
// Binary chip index plus broadcast flag to one-hot (or all-ones) chip select.
module scma_chip_sel_dec
    import scma_pkg::*;
(
    input  logic [CHIP_ID_WIDTH-1:0] chip,
    input  logic                     bcast,
    output logic [CHIP_EN_NUM-1:0]   sel
);

    always_comb begin
        sel = '0;
        if (bcast) begin
            sel = '1;
        end else begin
            sel[chip] = 1'b1;
        end
    end

endmodule

// File: rtl/scma_host_bridge.sv
// Sequences host write/broadcast-write/read commands onto the SCMA array bus,
// honouring full/empty with a bounded wait, and returns one in-order response per command.
module scma_host_bridge
    import scma_pkg::*;
#(
    parameter int unsigned READ_LAT = 2,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    scma_host_bridge_if.slave         host,
    output logic [A_WIDTH-1:0]        a_out,
    output logic [DATA_IN_WIDTH-1:0]  wdata_out,
    input  logic [DATA_OUT_WIDTH-1:0] arr_data,
    input  logic                      arr_empty,
    input  logic                      arr_full
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned LAT_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    state_e                    state_q, state_d;
    cmd_t                      cmd_q, cmd_d;
    logic [WAIT_W-1:0]         wait_cnt_q, wait_cnt_d;
    logic [LAT_W-1:0]          lat_cnt_q, lat_cnt_d;
    logic [DATA_OUT_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                      rsp_err_q, rsp_err_d;
    logic [CHIP_EN_NUM-1:0]    sel;
    logic                      accept;

    // Broadcast only widens the select for writes; broadcast reads never reach the array.
    scma_chip_sel_dec u_sel_dec (
        .chip  (cmd_q.chip),
        .bcast (cmd_q.bcast && (cmd_q.op == OP_WR)),
        .sel   (sel)
    );

    assign host.cmd_ready = (state_q == IDLE) && !rst;
    assign host.rsp_valid = (state_q == RESP) && !rst;
    assign host.rsp_data  = rsp_data_q;
    assign host.rsp_err   = rsp_err_q;
    assign accept         = host.cmd_valid && host.cmd_ready;

    always_comb begin
        a_out     = '0;
        wdata_out = '0;
        unique case (state_q)
            WRITE: begin
                a_out     = {sel, cmd_q.addr};
                wdata_out = cmd_q.data;
            end
            READ, RD_LAT: a_out = {sel, cmd_q.addr};
            default: ;
        endcase
    end

    // Counters default to zero so every state entry starts them cleared.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        wait_cnt_d = '0;
        lat_cnt_d  = '0;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cmd_d.op    = host.cmd_op;
                    cmd_d.bcast = host.cmd_bcast;
                    cmd_d.chip  = host.cmd_chip;
                    cmd_d.addr  = host.cmd_addr;
                    cmd_d.data  = host.cmd_data;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b0;
                    if (host.cmd_op == OP_WR) begin
                        state_d = WRITE;
                    end else if (!host.cmd_bcast) begin
                        state_d = READ;
                    end else begin
                        state_d   = RESP;
                        rsp_err_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (!arr_full) begin
                    state_d = RESP;
                end else if (wait_cnt_q == WAIT_W'(TIMEOUT)) begin
                    state_d   = RESP;
                    rsp_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            READ: begin
                if (!arr_empty) begin
                    state_d = RD_LAT;
                end else if (wait_cnt_q == WAIT_W'(TIMEOUT)) begin
                    state_d   = RESP;
                    rsp_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            RD_LAT: begin
                if (lat_cnt_q == LAT_W'(READ_LAT - 1)) begin
                    rsp_data_d = arr_data;
                    state_d    = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (host.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            wait_cnt_q <= '0;
            lat_cnt_q  <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            wait_cnt_q <= wait_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_scma_host_bridge.sv
// Directed, table-driven bench for scma_host_bridge with a per-cycle full/empty array model.
module tb_scma_host_bridge;
    import scma_pkg::*;

    localparam int STUCK = 100000;

    typedef struct {
        logic        op;
        logic        bcast;
        logic [3:0]  chip;
        logic [10:0] addr;
        logic [35:0] data;
        int          full_n;   // WRITE cycles that see arr_full=1 before it drops
        int          empty_n;  // READ cycles that see arr_empty=1 before it drops
        logic [31:0] arr_d;
        logic [15:0] exp_sel;
        int          exp_lat;  // cycles from accept edge to first rsp_valid
        int          exp_sc;   // cycles with nonzero a_out
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [A_WIDTH-1:0]        a_out;
    logic [DATA_IN_WIDTH-1:0]  wdata_out;
    logic [DATA_OUT_WIDTH-1:0] arr_data;
    logic                      arr_empty;
    logic                      arr_full;
    int                        tests = 0;
    int                        fails = 0;
    vec_t                      vecs [8];

    scma_host_bridge_if bus ();

    scma_host_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .host      (bus),
        .a_out     (a_out),
        .wdata_out (wdata_out),
        .arr_data  (arr_data),
        .arr_empty (arr_empty),
        .arr_full  (arr_full)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before 2 ms");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   n;
        int   cyc;
        int   sc;
        int   bad_sel;
        int   bad_wd;
        logic got;
        @(negedge clk);
        bus.cmd_op    = v.op;
        bus.cmd_bcast = v.bcast;
        bus.cmd_chip  = v.chip;
        bus.cmd_addr  = v.addr;
        bus.cmd_data  = v.data;
        bus.cmd_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        arr_data      = v.arr_d;
        arr_full      = 1'b0;
        arr_empty     = 1'b0;
        n = 0;
        while (!bus.cmd_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("v%0d cmd_ready", idx), 64'(bus.cmd_ready), 64'd1);
        cyc = 0; sc = 0; bad_sel = 0; bad_wd = 0; got = 1'b0;
        while (!got && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            bus.cmd_valid = 1'b0;
            if (a_out != '0) begin
                sc++;
                if (a_out !== {v.exp_sel, v.addr}) bad_sel++;
                if (v.op == OP_WR && wdata_out !== v.data) bad_wd++;
                arr_full  = (sc <= v.full_n);
                // empty drops for exactly one cycle, then reasserts during the latency window
                arr_empty = (sc <= v.empty_n) || (sc > v.empty_n + 1);
            end
            if (bus.rsp_valid) got = 1'b1;
        end
        check($sformatf("v%0d rsp_seen", idx), 64'(got), 64'd1);
        check($sformatf("v%0d latency", idx), 64'(cyc), 64'(v.exp_lat));
        check($sformatf("v%0d sel_cycles", idx), 64'(sc), 64'(v.exp_sc));
        check($sformatf("v%0d bad_sel", idx), 64'(bad_sel), 64'd0);
        check($sformatf("v%0d bad_wdata", idx), 64'(bad_wd), 64'd0);
        check($sformatf("v%0d rsp_err", idx), 64'(bus.rsp_err), 64'(v.exp_err));
        check($sformatf("v%0d rsp_data", idx), 64'(bus.rsp_data), 64'(v.exp_data));
        arr_full  = 1'b0;
        arr_empty = 1'b0;
    endtask

    initial begin
        int n;
        int bad;
        // op bcast chip addr data full_n empty_n arr_d | sel lat sc err data
        vecs[0] = '{1'b0, 1'b0, 4'd3, 11'h7FF, 36'h9_1234_5678, 0, 0, 32'h0,
                    16'h0008, 2, 1, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 4'd5, 11'h123, 36'hA_5A5A_5A5A, 5, 0, 32'h0,
                    16'hFFFF, 7, 6, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 4'd0, 11'h000, 36'hF_FFFF_FFFF, STUCK, 0, 32'h0,
                    16'hFFFF, 1025, 1024, 1'b1, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 4'd15, 11'h010, 36'h0, 0, 2, 32'hDEAD_BEEF,
                    16'h8000, 6, 5, 1'b0, 32'hDEAD_BEEF};
        vecs[4] = '{1'b1, 1'b0, 4'd0, 11'h400, 36'h0, 0, 0, 32'h1234_5678,
                    16'h0001, 4, 3, 1'b0, 32'h1234_5678};
        vecs[5] = '{1'b1, 1'b1, 4'd7, 11'h055, 36'h0, 0, 0, 32'h5555_AAAA,
                    16'h0000, 1, 0, 1'b1, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 4'd9, 11'h0F0, 36'h0, 0, STUCK, 32'h7777_7777,
                    16'h0200, 1025, 1024, 1'b1, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 4'd12, 11'h2AA, 36'h0_0000_0001, 0, 0, 32'h0,
                    16'h1000, 2, 1, 1'b0, 32'h0};

        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0; bus.cmd_bcast = 1'b0;
        bus.cmd_chip = '0; bus.cmd_addr = '0; bus.cmd_data = '0; bus.rsp_ready = 1'b0;
        arr_data = '0; arr_empty = 1'b0; arr_full = 1'b0;
        repeat (3) @(negedge clk);
        check("reset cmd_ready", 64'(bus.cmd_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset a_out", 64'(a_out), 64'd0);
        check("reset wdata", 64'(wdata_out), 64'd0);
        check("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("reset rsp_data", 64'(bus.rsp_data), 64'd0);
        check("reset rsp_err", 64'(bus.rsp_err), 64'd0);
        check("idle cmd_ready", 64'(bus.cmd_ready), 64'd1);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Response stall with a second command queued behind it
        @(negedge clk);
        bus.cmd_op = OP_RD; bus.cmd_bcast = 1'b0; bus.cmd_chip = 4'd2;
        bus.cmd_addr = 11'h055; bus.cmd_data = '0; bus.cmd_valid = 1'b1;
        bus.rsp_ready = 1'b0; arr_empty = 1'b0; arr_full = 1'b0; arr_data = 32'hCAFE_F00D;
        check("stall cmd_ready", 64'(bus.cmd_ready), 64'd1);
        @(negedge clk);
        bus.cmd_op = OP_WR; bus.cmd_chip = 4'd1; bus.cmd_addr = 11'h0AA;
        bus.cmd_data = 36'h3_0000_0003;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall read latency", 64'(n), 64'd3);
        bad = 0;
        repeat (4) begin
            if (!bus.rsp_valid || bus.rsp_data !== 32'hCAFE_F00D || bus.rsp_err
                || bus.cmd_ready) bad++;
            @(negedge clk);
        end
        check("stall stable", 64'(bad), 64'd0);
        check("stall rsp_data", 64'(bus.rsp_data), 64'hCAFE_F00D);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("b2b rsp_valid drop", 64'(bus.rsp_valid), 64'd0);
        check("b2b cmd_ready", 64'(bus.cmd_ready), 64'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("b2b second a_out", 64'(a_out), 64'({16'h0002, 11'h0AA}));
        check("b2b second wdata", 64'(wdata_out), 64'h3_0000_0003);
        @(negedge clk);
        check("b2b second rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("b2b second rsp_err", 64'(bus.rsp_err), 64'd0);
        check("b2b second rsp_data", 64'(bus.rsp_data), 64'd0);

        // Reset during the READ wait abandons the command
        @(negedge clk);
        bus.cmd_op = OP_RD; bus.cmd_bcast = 1'b0; bus.cmd_chip = 4'd4;
        bus.cmd_addr = 11'h321; bus.cmd_valid = 1'b1; arr_empty = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("rst-mid a_out before", 64'(a_out), 64'({16'h0010, 11'h321}));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst-mid a_out", 64'(a_out), 64'd0);
        check("rst-mid rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst-mid cmd_ready", 64'(bus.cmd_ready), 64'd0);
        rst = 1'b0;
        arr_empty = 1'b0;
        run_vec(vecs[7], 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
